// File: rtl/mux_scan_pkg.sv
// Shared constants and types for the 4:1 mux scan sequencer.
package mux_scan_pkg;

    localparam int NCH       = 4;
    localparam int SEL_W     = 2;
    localparam int DWELL_MIN = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage : mux_scan_pkg

// File: rtl/mux_next_ch.sv
// Picks the next enabled channel: lowest set bit overall (first=1) or lowest set bit above cur.
module mux_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NCH-1:0]   en,
    input  logic [SEL_W-1:0] cur,
    input  logic             first,
    output logic [SEL_W-1:0] nxt,
    output logic             found
);

    // Scanning downwards lets the last hit be the lowest qualifying index.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        nxt   = '0;
        found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (en[i] && (first || (SEL_W'(i) > cur))) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule : mux_next_ch

// File: rtl/mux_scan_ctrl.sv
// Steps the 4:1 mux select through enabled channels, samples y once per dwell and
// reports a 4-bit snapshot with a one-cycle valid pulse at scan end.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NCH-1:0]   ch_en,
    input  logic             y,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic [NCH-1:0]   snap,
    output logic             snap_valid
);

    localparam int             CW       = $clog2(DWELL);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [NCH-1:0]   r_en_q;
    logic [SEL_W-1:0] r_sel;
    logic             r_busy;
    logic [NCH-1:0]   r_snap;
    logic             r_snap_valid;

    state_t           w_state_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [NCH-1:0]   w_en_q_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic             w_busy_nxt;
    logic [NCH-1:0]   w_snap_nxt;
    logic             w_snap_valid_nxt;

    logic [NCH-1:0]   w_en_src;
    logic             w_first;
    logic [SEL_W-1:0] w_next_ch;
    logic             w_found;
    logic             w_sample;
    logic             w_advance;

    // In IDLE the live mask picks the first channel; during a scan the latched mask picks the next.
    assign w_first  = (r_state == IDLE);
    assign w_en_src = w_first ? ch_en : r_en_q;

    mux_next_ch u_next_ch (
        .en    (w_en_src),
        .cur   (r_sel),
        .first (w_first),
        .nxt   (w_next_ch),
        .found (w_found)
    );

    // The counter is loaded with 1 on the edge that first drives a channel, so the sample
    // lands on the last cycle of the dwell and the select moves on the edge after it.
    assign w_sample  = (r_state == SCAN) && (r_cnt == CNT_LAST);
    assign w_advance = (r_state == SCAN) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_en_q       <= '0;
            r_sel        <= '0;
            r_busy       <= 1'b0;
            r_snap       <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_en_q       <= w_en_q_nxt;
            r_sel        <= w_sel_nxt;
            r_busy       <= w_busy_nxt;
            r_snap       <= w_snap_nxt;
            r_snap_valid <= w_snap_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (start && w_found) w_state_nxt = SCAN;
            SCAN: if (w_sample && !w_found) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt        = r_cnt;
        w_en_q_nxt       = r_en_q;
        w_sel_nxt        = r_sel;
        w_busy_nxt       = r_busy;
        w_snap_nxt       = r_snap;
        w_snap_valid_nxt = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_snap_nxt = '0;
                    if (w_found) begin
                        w_en_q_nxt = ch_en;
                        w_sel_nxt  = w_next_ch;
                        w_cnt_nxt  = CNT_ONE;
                        w_busy_nxt = 1'b1;
                    end else begin
                        // Empty mask: report an all-zero snapshot without ever going busy.
                        w_snap_valid_nxt = 1'b1;
                    end
                end
            end
            SCAN: begin
                w_cnt_nxt = r_cnt + CNT_ONE;
                if (w_sample) begin
                    w_snap_nxt[r_sel] = y;
                    w_cnt_nxt         = '0;
                    if (!w_found) begin
                        w_busy_nxt       = 1'b0;
                        w_snap_valid_nxt = 1'b1;
                    end
                end else if (w_advance) begin
                    w_sel_nxt = w_next_ch;
                end
            end
            default: begin
                w_cnt_nxt  = '0;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign sel        = r_sel;
    assign busy       = r_busy;
    assign snap       = r_snap;
    assign snap_valid = r_snap_valid;

endmodule : mux_scan_ctrl

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl driving a behavioural 4:1 mux with d0..d3 = 0,1,0,1.
module tb_mux_scan_ctrl;

    localparam int         DWELL  = 4;
    localparam logic [3:0] D_VALS = 4'b1010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] ch_en;
    logic       y;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] snap;
    logic       snap_valid;

    logic [3:0] sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for mux_4to1 with static data inputs.
    assign y = D_VALS[sel];

    mux_scan_ctrl #(.DWELL(DWELL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ch_en      (ch_en),
        .y          (y),
        .sel        (sel),
        .busy       (busy),
        .snap       (snap),
        .snap_valid (snap_valid)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        ch_en = 4'b0000;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (sel !== 2'd0)     begin n_errors++; $display("FAIL reset_async_sel: got %0d want 0", sel); end
        n_checks++; if (busy !== 1'b0)    begin n_errors++; $display("FAIL reset_async_busy: got %b want 0", busy); end
        n_checks++; if (snap !== 4'b0)    begin n_errors++; $display("FAIL reset_async_snap: got %b want 0000", snap); end
        n_checks++; if (snap_valid !== 1'b0) begin n_errors++; $display("FAIL reset_async_valid: got %b want 0", snap_valid); end
        repeat (3) @(negedge clk);
        n_checks++; if (sel !== 2'd0)     begin n_errors++; $display("FAIL reset_hold_sel: got %0d want 0", sel); end
        n_checks++; if (busy !== 1'b0)    begin n_errors++; $display("FAIL reset_hold_busy: got %b want 0", busy); end
        n_checks++; if (snap !== 4'b0)    begin n_errors++; $display("FAIL reset_hold_snap: got %b want 0000", snap); end
        n_checks++; if (snap_valid !== 1'b0) begin n_errors++; $display("FAIL reset_hold_valid: got %b want 0", snap_valid); end
        rst_n = 1'b1;
    endtask

    // Starts a scan at the next posedge (call between a negedge and the following posedge),
    // checks sel/busy/snap_valid every cycle and pops the scoreboard on snap_valid.
    // inject_at > 0 asserts start with ch_en=1111 so it is sampled at edge inject_at.
    task automatic do_scan(input logic [3:0] en, input string name, input int inject_at);
        int         chans[$];
        int         n;
        logic [1:0] exp_sel;
        logic       exp_busy;
        logic [3:0] exp_snap;
        for (int i = 0; i < 4; i++) if (en[i]) chans.push_back(i);
        n = chans.size();
        sb_q.push_back(en & D_VALS);
        ch_en = en;
        start = 1'b1;
        for (int e = 0; e < n * DWELL; e++) begin
            @(negedge clk);
            start    = 1'b0;
            ch_en    = ~en;
            exp_sel  = 2'(chans[e / DWELL]);
            exp_busy = (e != n * DWELL - 1);
            n_checks++; if (sel !== exp_sel) begin n_errors++; $display("FAIL %s_sel edge %0d: got %0d want %0d", name, e, sel, exp_sel); end
            n_checks++; if (busy !== exp_busy) begin n_errors++; $display("FAIL %s_busy edge %0d: got %b want %b", name, e, busy, exp_busy); end
            n_checks++; if (snap_valid !== !exp_busy) begin n_errors++; $display("FAIL %s_valid edge %0d: got %b want %b", name, e, snap_valid, !exp_busy); end
            if (snap_valid === 1'b1) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++; $display("FAIL %s_snap edge %0d: got pulse, scoreboard empty", name, e);
                end else begin
                    exp_snap = sb_q.pop_front();
                    if (snap !== exp_snap) begin n_errors++; $display("FAIL %s_snap: got %b want %b", name, snap, exp_snap); end
                end
            end
            if (e == inject_at - 1) begin
                start = 1'b1;
                ch_en = 4'b1111;
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++; $display("FAIL %s_done: got %0d pending results want 0", name, sb_q.size());
            sb_q.delete();
        end
        if (inject_at > 0) begin
            @(negedge clk);
            start = 1'b0;
            n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL %s_idle_busy: got %b want 0", name, busy); end
            n_checks++; if (snap_valid !== 1'b0) begin n_errors++; $display("FAIL %s_idle_valid: got %b want 0", name, snap_valid); end
        end
    endtask

    task automatic test_full();
        do_scan(4'b1111, "full", -1);
    endtask

    task automatic test_sparse();
        do_scan(4'b1010, "sparse", 2 * DWELL - 1);
    endtask

    task automatic test_zero();
        logic [3:0] exp_snap;
        @(negedge clk);
        n_checks++; if (snap !== 4'b1010) begin n_errors++; $display("FAIL zero_hold_snap: got %b want 1010", snap); end
        sb_q.push_back(4'b0000);
        ch_en = 4'b0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL zero_busy: got %b want 0", busy); end
        n_checks++; if (snap_valid !== 1'b1) begin n_errors++; $display("FAIL zero_valid: got %b want 1", snap_valid); end
        if (snap_valid === 1'b1 && sb_q.size() != 0) begin
            exp_snap = sb_q.pop_front();
            n_checks++; if (snap !== exp_snap) begin n_errors++; $display("FAIL zero_snap: got %b want %b", snap, exp_snap); end
        end
        sb_q.delete();
        @(negedge clk);
        n_checks++; if (snap_valid !== 1'b0) begin n_errors++; $display("FAIL zero_pulse_width: got %b want 0", snap_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL zero_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_busy_ignore();
        do_scan(4'b0001, "ignore", 2);
    endtask

    task automatic test_back_to_back();
        do_scan(4'b0001, "b2b_a", -1);
        do_scan(4'b1001, "b2b_b", -1);
        do_scan(4'b0110, "b2b_c", -1);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        sb_q.push_back(4'b1010);
        ch_en = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (sel !== 2'd1) begin n_errors++; $display("FAIL midrst_pre_sel: got %0d want 1", sel); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (sel !== 2'd0)  begin n_errors++; $display("FAIL midrst_sel: got %0d want 0", sel); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_checks++; if (snap !== 4'b0) begin n_errors++; $display("FAIL midrst_snap: got %b want 0000", snap); end
        n_checks++; if (snap_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b want 0", snap_valid); end
        repeat (2) @(negedge clk);
        n_checks++; if (snap_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_no_pulse: got %b want 0", snap_valid); end
        rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_release_busy: got %b want 0", busy); end
        do_scan(4'b1111, "rerun", -1);
    endtask

    initial begin
        test_reset();
        test_full();
        test_sparse();
        test_zero();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mux_scan_ctrl
